serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/full_subtractor_df.sv | 21 ++
 rtl/serial_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared state encodings and default width for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused and steers back to STATE_IDLE.
    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_SHIFT = 2'd1,
        STATE_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_df.sv
// ============================================================================
// Module      : full_subtractor_df
// Description : Dataflow full-subtractor cell: diff = a - b - c, borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_df (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borr
);

    assign diff = a ^ b ^ c;
    assign borr = (~a & b) | (~a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, LSB first, one full-subtractor cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_done;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    full_subtractor_df u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .c    (r_brw),
        .diff (w_d),
        .borr (w_bo)
    );

    // r_acc keeps only the upper WIDTH-1 result bits; the new bit joins at the top.
    always_comb begin
        w_acc_next = {w_d, r_acc};
        w_last     = (r_cnt == C_LAST);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE:  if (start) w_state_next = STATE_SHIFT;
            STATE_SHIFT: if (w_last) w_state_next = STATE_DONE;
            STATE_DONE:  w_state_next = STATE_IDLE;
            default:     w_state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STATE_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                STATE_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_brw <= bin;
                        r_cnt <= '0;
                    end
                end
                STATE_SHIFT: begin
                    r_acc <= w_acc_next[WIDTH-1:1];
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_brw <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= w_acc_next;
                        r_bout <= w_bo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != STATE_IDLE);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire
